// File: rtl/rat_io_pkg.sv
// -----------------------------------------------------------------------------
// rat_io_pkg
// Shared definitions for the RAT I/O bus peripherals.
//   - Port ID constants decoded by the wrapper and the peripherals.
//   - uart_tx_state_t: state encoding of the UART transmitter FSM.
// -----------------------------------------------------------------------------
package rat_io_pkg;

    localparam logic [7:0] SWITCHES_ID    = 8'h9A;
    localparam logic [7:0] BTN_ID         = 8'h9B;
    localparam logic [7:0] LEDS_ID        = 8'h42;
    localparam logic [7:0] SSEG_ID        = 8'h81;
    localparam logic [7:0] UART_DATA_ID   = 8'h40;
    localparam logic [7:0] UART_STATUS_ID = 8'h41;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/rat_uart_tx_if.sv
// -----------------------------------------------------------------------------
// rat_uart_tx_if
// CPU-side RAT I/O bus as seen by a port-mapped peripheral.
//   PORT_ID     8  port ID driven by the CPU
//   OUT_PORT    8  CPU output data
//   IO_STRB     1  CPU output strobe
//   STATUS_DATA 8  peripheral read data back to the wrapper's input mux
// master: the CPU/wrapper side. slave: the peripheral.
// -----------------------------------------------------------------------------
interface rat_uart_tx_if;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] STATUS_DATA;

    modport master (
        output PORT_ID,
        output OUT_PORT,
        output IO_STRB,
        input  STATUS_DATA
    );

    modport slave (
        input  PORT_ID,
        input  OUT_PORT,
        input  IO_STRB,
        output STATUS_DATA
    );
endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO.
//   clk_i    clock
//   rst_ni   asynchronous active-low reset (pointers and count only)
//   push_i   write din_i; accepted when not full, or when full with a pop
//            in the same cycle
//   pop_i    discard head; ignored when empty
//   din_i    write data
//   dout_o   head entry, valid whenever empty_o is low
//   empty_o  count == 0
//   full_o   count == DEPTH
//   count_o  number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head leaves in the same
    // cycle: the freed slot is the one being overwritten next.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rat_uart_tx.sv
// -----------------------------------------------------------------------------
// rat_uart_tx
// Port-mapped 8N1 UART transmitter on the RAT I/O bus.
//   CLK      system clock (board clock, faster than the CPU clock)
//   RESET_N  asynchronous active-low reset
//   io       RAT I/O bus (slave): OUT to DATA_ID queues a byte, OUT to
//            STATUS_ID with bit 3 set clears the overflow flag; STATUS_DATA
//            returns {4'b0, ovf, busy, full, empty} when PORT_ID==STATUS_ID
//   TX       serial line, idle high, registered
//   TX_BUSY  high from the first start-bit cycle to the last stop-bit cycle
// -----------------------------------------------------------------------------
module rat_uart_tx
    import rat_io_pkg::*;
#(
    parameter logic [7:0] DATA_ID   = UART_DATA_ID,
    parameter logic [7:0] STATUS_ID = UART_STATUS_ID,
    parameter int         CLK_HZ    = 100_000_000,
    parameter int         BAUD      = 115_200,
    parameter int         DEPTH     = 8
) (
    input  logic            CLK,
    input  logic            RESET_N,
    rat_uart_tx_if.slave    io,
    output logic            TX,
    output logic            TX_BUSY
);

    localparam int               CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int               DIV_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLKS_PER_BIT - 1);
    localparam int               CNT_W        = $clog2(DEPTH) + 1;

    // Strobe edge detect: the CPU strobe spans several fast clocks, so only
    // its rising edge counts as a write.
    logic strb_q;
    logic wr;
    logic data_wr;
    logic ovf_clr;
    logic ovf_q;

    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;

    uart_tx_state_t   state_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             busy_q;
    logic             div_last;

    assign wr      = io.IO_STRB & ~strb_q;
    assign data_wr = wr & (io.PORT_ID == DATA_ID);
    assign ovf_clr = wr & (io.PORT_ID == STATUS_ID) & io.OUT_PORT[3];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            strb_q <= 1'b0;
        end else begin
            strb_q <= io.IO_STRB;
        end
    end

    // Sticky overflow: a byte is lost only when the queue is full and no
    // slot is freed in the same cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ovf_q <= 1'b0;
        end else if (data_wr & fifo_full & ~fifo_pop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .push_i  (data_wr),
        .pop_i   (fifo_pop),
        .din_i   (io.OUT_PORT),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // The head leaves the queue on the same cycle the FSM latches it.
    assign fifo_pop = (state_q == IDLE) && (fifo_count != '0);
    assign div_last = (div_q == DIV_LAST);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    div_q  <= '0;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (fifo_pop) begin
                        shift_q   <= fifo_dout;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (div_last) begin
                        div_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                DATA: begin
                    if (div_last) begin
                        div_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            // Next bit is already sitting at position 1.
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                STOP: begin
                    if (div_last) begin
                        div_q   <= '0;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign TX      = tx_q;
    assign TX_BUSY = busy_q;

    assign io.STATUS_DATA = (io.PORT_ID == STATUS_ID)
                          ? {4'b0000, ovf_q, busy_q, fifo_full, fifo_empty}
                          : 8'h00;

endmodule

// File: tb/tb_rat_uart_tx.sv
module tb_rat_uart_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tx;
    logic tx_busy;
    int   cyc   = 0;

    int tests_run = 0;
    int fails     = 0;

    rat_uart_tx_if io_if ();

    rat_uart_tx #(
        .CLK_HZ (400),
        .BAUD   (100)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .io      (io_if),
        .TX      (tx),
        .TX_BUSY (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    // UART line monitor (4 clocks per bit): samples each bit mid-period.
    logic [7:0] rx_q[$];
    int         start_q[$];
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic       mon_prev   = 1'b1;
    logic [7:0] mon_byte   = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
            mon_prev   = 1'b1;
        end else begin
            if (!mon_active) begin
                if (mon_prev && !tx) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                mon_cnt++;
                if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2)
                    mon_byte[3'((mon_cnt - 6) / 4)] = tx;
                if (mon_cnt == 38) begin
                    check("stop_bit", {31'b0, tx}, 32'd1);
                    rx_q.push_back(mon_byte);
                    $display("[TB] rx byte %02h", mon_byte);
                end
                if (mon_cnt == 39) mon_active = 1'b0;
            end
            mon_prev = tx;
        end
    end

    task automatic do_write(input logic [7:0] id, input logic [7:0] data);
        @(negedge clk);
        io_if.PORT_ID  = id;
        io_if.OUT_PORT = data;
        io_if.IO_STRB  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        io_if.IO_STRB  = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= n) break;
            @(negedge clk);
        end
        check("rx_count", rx_q.size(), n);
    endtask

    typedef struct {
        logic [7:0] port_id;
        logic [7:0] data;
        logic       wr;
        logic [7:0] exp_status;
        logic       exp_tx;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic exp_bit;
        logic [7:0] a5;
        int lows;

        vecs[0] = '{8'h42, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[1] = '{8'h9A, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'h41, 8'h00, 1'b0, 8'h01, 1'b1};
        vecs[3] = '{8'h40, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{8'h41, 8'hF7, 1'b1, 8'h01, 1'b1};
        vecs[5] = '{8'h81, 8'h3C, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h9B, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{8'h41, 8'h00, 1'b0, 8'h01, 1'b1};

        io_if.PORT_ID  = 8'h41;
        io_if.OUT_PORT = 8'h00;
        io_if.IO_STRB  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_busy", {31'b0, tx_busy}, 32'd0);
        check("reset_status", {24'b0, io_if.STATUS_DATA}, 32'h01);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Unmatched IDs and status reads.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            io_if.PORT_ID  = vecs[i].port_id;
            io_if.OUT_PORT = vecs[i].data;
            io_if.IO_STRB  = vecs[i].wr;
            @(negedge clk);
            @(negedge clk);
            io_if.IO_STRB  = 1'b0;
            @(negedge clk);
            #1;
            $display("[TB] vec %0d id=%02h data=%02h wr=%0b", i, vecs[i].port_id, vecs[i].data, vecs[i].wr);
            check("vec_status", {24'b0, io_if.STATUS_DATA}, {24'b0, vecs[i].exp_status});
            check("vec_tx", {31'b0, tx}, {31'b0, vecs[i].exp_tx});
        end
        check("vec_no_frames", start_q.size(), 0);

        // Single byte A5: exact waveform from the write cycle.
        a5 = 8'hA5;
        @(negedge clk);
        io_if.PORT_ID  = 8'h40;
        io_if.OUT_PORT = a5;
        io_if.IO_STRB  = 1'b1;
        for (int i = 1; i <= 42; i++) begin
            @(negedge clk);
            #1;
            if (i >= 2 && i <= 5)        exp_bit = 1'b0;
            else if (i >= 6 && i <= 37)  exp_bit = a5[3'((i - 6) / 4)];
            else                         exp_bit = 1'b1;
            check($sformatf("a5_tx[%0d]", i), {31'b0, tx}, {31'b0, exp_bit});
            check($sformatf("a5_busy[%0d]", i), {31'b0, tx_busy}, (i >= 2 && i <= 41) ? 32'd1 : 32'd0);
            if (i == 2) io_if.IO_STRB = 1'b0;
        end
        io_if.PORT_ID = 8'h41;
        repeat (10) @(negedge clk);
        #1;
        check("a5_status_idle", {24'b0, io_if.STATUS_DATA}, 32'h01);
        check("a5_frames", start_q.size(), 1);
        check("a5_rx_count", rx_q.size(), 1);
        if (rx_q.size() >= 1) check("a5_rx", {24'b0, rx_q[0]}, 32'hA5);

        // Burst of 9 while idle: no overflow, back-to-back frames.
        rx_q.delete();
        start_q.delete();
        for (int b = 1; b <= 9; b++) do_write(8'h40, 8'(b));
        wait_rx(9, 600);
        for (int k = 0; k < rx_q.size(); k++)
            check($sformatf("burst_rx[%0d]", k), {24'b0, rx_q[k]}, k + 1);
        for (int k = 1; k < start_q.size(); k++)
            check($sformatf("burst_gap[%0d]", k), start_q[k] - start_q[k-1], 41);
        @(negedge clk);
        io_if.PORT_ID = 8'h41;
        #1;
        check("burst_status", {24'b0, io_if.STATUS_DATA}, 32'h01);

        // Burst of 10 during the first frame: last byte dropped.
        rx_q.delete();
        start_q.delete();
        for (int b = 0; b < 10; b++) do_write(8'h40, 8'h10 + 8'(b));
        @(negedge clk);
        io_if.PORT_ID = 8'h41;
        #1;
        check("ovf_status", {24'b0, io_if.STATUS_DATA}, 32'h0E);
        do_write(8'h41, 8'h08);
        @(negedge clk);
        #1;
        check("ovf_cleared", {24'b0, io_if.STATUS_DATA}, 32'h06);

        // Push lands on the pop cycle with the FIFO full.
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                if (!tx_busy) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("pp_idle_seen", {31'b0, seen}, 32'd1);
        end
        io_if.PORT_ID  = 8'h40;
        io_if.OUT_PORT = 8'h77;
        io_if.IO_STRB  = 1'b1;
        @(negedge clk);
        io_if.PORT_ID = 8'h41;
        #1;
        check("pp_status", {24'b0, io_if.STATUS_DATA}, 32'h06);
        @(negedge clk);
        io_if.IO_STRB = 1'b0;
        wait_rx(10, 700);
        for (int k = 0; k < rx_q.size(); k++)
            check($sformatf("ovf_rx[%0d]", k), {24'b0, rx_q[k]}, (k < 9) ? 32'h10 + k : 32'h77);

        // Reset in the middle of a DATA bit.
        rx_q.delete();
        start_q.delete();
        for (int b = 0; b < 3; b++) do_write(8'h40, 8'h00);
        for (int i = 0; i < 50; i++) begin
            if (start_q.size() >= 1) break;
            @(negedge clk);
        end
        check("rst_frame_started", {31'b0, start_q.size() >= 1}, 32'd1);
        repeat (12) @(negedge clk);
        io_if.PORT_ID = 8'h41;
        #1;
        check("rst_pre_tx", {31'b0, tx}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_busy", {31'b0, tx_busy}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_status", {24'b0, io_if.STATUS_DATA}, 32'h01);
        lows = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (!tx) lows++;
        end
        check("rst_no_tx", lows, 0);
        check("rst_no_rx", rx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
